// File: rtl/mvec_collector.sv
// mvec_collector: sequences one req/ack transaction per block for me_double,
// queues each tagged result in a small FIFO, and tracks the frame-best SAD.
module mvec_collector #(
  parameter int NUM_BLOCKS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  blk_idx,
  output logic        me_req,
  input  logic        me_ack,
  input  logic [15:0] me_min_sad,
  input  logic [9:0]  me_min_mvec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [33:0] out_data,
  output logic [15:0] best_sad,
  output logic [7:0]  best_idx
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_me_req;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_blk_idx;
  logic [15:0]   r_best_sad;
  logic [7:0]    r_best_idx;

  logic [33:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_capture;
  logic          w_pop;
  logic          w_last;

  // Push eligibility looks only at the registered count, so a same-cycle pop
  // never makes room for a capture.
  assign w_full    = (r_count == FULL_CNT);
  assign w_capture = (r_state == S_REQ) && me_ack && !w_full;
  assign w_pop     = out_valid && out_ready;
  assign w_last    = (r_blk_idx == LAST_IDX);

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign me_req    = r_me_req;
  assign busy      = r_busy;
  assign done      = r_done;
  assign blk_idx   = r_blk_idx;
  assign best_sad  = r_best_sad;
  assign best_idx  = r_best_idx;

  // Next-state decode for the per-block four-phase handshake.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_REQ;
      S_REQ:   if (w_capture) w_state_nxt = S_REL;
      S_REL:   if (!me_ack) w_state_nxt = w_last ? S_DONE : S_REQ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; req/busy/done are registered from the next state so they
  // change exactly on the edge the state does.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      r_state  <= S_IDLE;
      r_me_req <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_me_req <= (w_state_nxt == S_REQ);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  // Block index and frame-best tracking; held after DONE until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_idx  <= '0;
      r_best_sad <= 16'hFFFF;
      r_best_idx <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_blk_idx  <= '0;
      r_best_sad <= 16'hFFFF;
      r_best_idx <= '0;
    end else begin
      if (r_state == S_REL && !me_ack && !w_last)
        r_blk_idx <= r_blk_idx + 8'd1;
      // Strict compare: on a tie the earlier block keeps the title.
      if (w_capture && (me_min_sad < r_best_sad)) begin
        r_best_sad <= me_min_sad;
        r_best_idx <= r_blk_idx;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; out_valid gates it, so stale contents are never observed.
    if (w_capture)
      r_mem[r_wr_ptr] <= {r_blk_idx, me_min_sad, me_min_mvec};
  end

  // FIFO pointers and occupancy count; not cleared at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_capture) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mvec_collector.sv
// Directed bench for mvec_collector: a 4-block instance with a 2-entry FIFO
// driven by a behavioural ME, plus a 1-block instance driven by hand.
module tb_mvec_collector;

  localparam logic [9:0] MVEC = {5'd3, 5'd5};

  logic        clk = 1'b0;
  logic        rst;
  int          errors = 0;
  int          checks = 0;

  // Main instance (NUM_BLOCKS=4, FIFO_DEPTH=2)
  logic        start, busy, done, me_req, me_ack, out_valid, out_ready;
  logic [7:0]  blk_idx, best_idx;
  logic [15:0] me_min_sad, best_sad;
  logic [9:0]  me_min_mvec;
  logic [33:0] out_data;

  // Single-block instance (NUM_BLOCKS=1, FIFO_DEPTH=2)
  logic        start1, busy1, done1, me_req1, ack1, out_valid1, out_ready1;
  logic [7:0]  blk_idx1, best_idx1;
  logic [15:0] sad1, best_sad1;
  logic [9:0]  mvec1;
  logic [33:0] out_data1;

  // Behavioural ME controls and monitor state
  int          me_lat  = 20;
  int          me_hold = 0;
  int          me_cnt  = 0;
  logic [15:0] sad_tab [4] = '{16'd300, 16'd120, 16'd450, 16'd120};

  logic [33:0] popped [$];
  logic [7:0]  blk_seq [$];
  int          done_cnt  = 0;
  int          hs_viol   = 0;
  int          min_low   = 1000;
  int          low_run   = 0;
  bit          seen_high = 0;
  logic        prev_req  = 1'b0;

  always #5 clk = ~clk;

  mvec_collector #(.NUM_BLOCKS(4), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .blk_idx(blk_idx), .me_req(me_req), .me_ack(me_ack),
    .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .best_sad(best_sad), .best_idx(best_idx)
  );

  mvec_collector #(.NUM_BLOCKS(1), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .blk_idx(blk_idx1), .me_req(me_req1), .me_ack(ack1),
    .me_min_sad(sad1), .me_min_mvec(mvec1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .best_sad(best_sad1), .best_idx(best_idx1)
  );

  function automatic logic [33:0] exp_entry(input int i);
    logic [7:0] idx;
    idx = 8'(i);
    return {idx, sad_tab[i], MVEC};
  endfunction

  // Behavioural ME: ack me_lat cycles after req, drop ack me_hold cycles after req falls.
  initial begin
    me_ack = 1'b0;
    me_min_sad = '0;
    me_min_mvec = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        me_ack = 1'b0;
        me_cnt = 0;
      end else if (!me_ack) begin
        if (me_req) begin
          me_cnt++;
          if (me_cnt >= me_lat) begin
            me_ack = 1'b1;
            me_min_sad = sad_tab[blk_idx[1:0]];
            me_min_mvec = MVEC;
            me_cnt = 0;
          end
        end else me_cnt = 0;
      end else begin
        if (!me_req) begin
          me_cnt++;
          if (me_cnt > me_hold) begin
            me_ack = 1'b0;
            me_cnt = 0;
          end
        end else me_cnt = 0;
      end
    end
  end

  // Monitor: pops, done pulses, requested block indices, req low time, handshake order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) popped.push_back(out_data);
        if (done) done_cnt++;
        if (me_req && !prev_req) begin
          blk_seq.push_back(blk_idx);
          if (me_ack) hs_viol++;
          if (seen_high && low_run < min_low) min_low = low_run;
        end
        if (me_req) begin
          low_run = 0;
          seen_high = 1;
        end else low_run++;
      end
      prev_req = me_req;
    end
  end

  task automatic clear_mon();
    popped.delete();
    blk_seq.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s: done not seen within 2000 cycles", name);
    end
  endtask

  task automatic wait_blk_req(input int idx, input bit need_ack, input string name);
    int n = 0;
    while (!(me_req === 1'b1 && blk_idx === 8'(idx) && (!need_ack || me_ack === 1'b1)) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s: block %0d request not seen within 2000 cycles", name, idx);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (out_valid === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: FIFO did not drain, out_valid=%0b", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; ack1 = 1'b0; sad1 = '0; mvec1 = '0; out_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (me_req !== 1'b0) begin errors++; $display("FAIL reset_me_req: got %0b want 0", me_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (blk_idx !== 8'd0) begin errors++; $display("FAIL reset_blk_idx: got %0d want 0", blk_idx); end
    checks++; if (best_sad !== 16'hFFFF) begin errors++; $display("FAIL reset_best_sad: got %h want ffff", best_sad); end
    checks++; if (best_idx !== 8'd0) begin errors++; $display("FAIL reset_best_idx: got %0d want 0", best_idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_valid1 !== 1'b0 || me_req1 !== 1'b0) begin errors++; $display("FAIL reset_inst1: out_valid=%0b me_req=%0b want 0/0", out_valid1, me_req1); end
  endtask

  task automatic test_basic_frame();
    clear_mon();
    me_lat = 20; me_hold = 0; out_ready = 1'b1;
    pulse_start();
    checks++; if (busy !== 1'b1 || me_req !== 1'b1) begin errors++; $display("FAIL basic_start: busy=%0b me_req=%0b want 1/1", busy, me_req); end
    wait_done("basic_done");
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%0b done=%0b want 0/0", busy, done); end
    wait_drain("basic_drain");
    checks++; if (popped.size() != 4) begin errors++; $display("FAIL basic_count: got %0d entries want 4", popped.size()); end
    for (int i = 0; i < 4 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== exp_entry(i)) begin errors++; $display("FAIL basic_entry%0d: got %h want %h", i, popped[i], exp_entry(i)); end
    end
    checks++; if (best_sad !== 16'd120 || best_idx !== 8'd1) begin errors++; $display("FAIL basic_best: got %0d@%0d want 120@1", best_sad, best_idx); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int n_before;
    clear_mon();
    me_lat = 5; me_hold = 0; out_ready = 1'b0;
    pulse_start();
    wait_blk_req(2, 1'b1, "bp_stall_reach");
    repeat (3) @(posedge clk);
    #1;
    checks++; if (me_req !== 1'b1 || blk_idx !== 8'd2) begin errors++; $display("FAIL bp_stall: me_req=%0b blk=%0d want 1/2", me_req, blk_idx); end
    checks++; if (popped.size() != 0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_full: pops=%0d out_valid=%0b want 0/1", popped.size(), out_valid); end
    n_before = popped.size();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (me_req !== 1'b1) begin errors++; $display("FAIL bp_no_same_cycle_push: me_req=%0b want 1", me_req); end
    @(posedge clk); #1;
    checks++; if (me_req !== 1'b0) begin errors++; $display("FAIL bp_capture_next: me_req=%0b want 0", me_req); end
    checks++; if (popped.size() != n_before + 1) begin errors++; $display("FAIL bp_one_pop: got %0d pops want %0d", popped.size(), n_before + 1); end
    out_ready = 1'b1;
    wait_done("bp_done");
    wait_drain("bp_drain");
    checks++; if (popped.size() != 4) begin errors++; $display("FAIL bp_count: got %0d entries want 4", popped.size()); end
    for (int i = 0; i < 4 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== exp_entry(i)) begin errors++; $display("FAIL bp_entry%0d: got %h want %h", i, popped[i], exp_entry(i)); end
    end
  endtask

  task automatic test_handshake();
    clear_mon();
    me_lat = 3; me_hold = 10; out_ready = 1'b1;
    hs_viol = 0; min_low = 1000; seen_high = 0; low_run = 0;
    pulse_start();
    wait_done("hs_done");
    wait_drain("hs_drain");
    checks++; if (hs_viol != 0) begin errors++; $display("FAIL hs_order: %0d req rises while ack high, want 0", hs_viol); end
    checks++; if (min_low < 10) begin errors++; $display("FAIL hs_low_time: min req low %0d cycles want >= 10", min_low); end
    checks++; if (blk_seq.size() != 4) begin errors++; $display("FAIL hs_blocks: got %0d requests want 4", blk_seq.size()); end
    me_hold = 0;
  endtask

  task automatic test_ignored_start();
    clear_mon();
    me_lat = 8; me_hold = 0; out_ready = 1'b1;
    pulse_start();
    wait_blk_req(1, 1'b0, "ign_reach");
    pulse_start();
    wait_done("ign_done");
    repeat (5) @(posedge clk);
    #1;
    checks++; if (blk_seq.size() != 4) begin errors++; $display("FAIL ign_seq_len: got %0d requests want 4", blk_seq.size()); end
    for (int i = 0; i < 4 && i < blk_seq.size(); i++) begin
      checks++;
      if (blk_seq[i] !== 8'(i)) begin errors++; $display("FAIL ign_seq%0d: got %0d want %0d", i, blk_seq[i], i); end
    end
    checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL ign_single_done: dones=%0d busy=%0b want 1/0", done_cnt, busy); end
    wait_drain("ign_drain");
  endtask

  task automatic test_reset_mid();
    clear_mon();
    me_lat = 20; me_hold = 0; out_ready = 1'b0;
    pulse_start();
    wait_blk_req(2, 1'b0, "rm_reach");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || best_sad !== 16'd120) begin errors++; $display("FAIL rm_pre: out_valid=%0b best=%0d want 1/120", out_valid, best_sad); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (me_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_req_fifo: me_req=%0b out_valid=%0b want 0/0", me_req, out_valid); end
    checks++; if (best_sad !== 16'hFFFF || blk_idx !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL rm_state: best=%h blk=%0d busy=%0b want ffff/0/0", best_sad, blk_idx, busy); end
    repeat (3) @(posedge clk);
    #1;
    clear_mon();
    out_ready = 1'b1;
    pulse_start();
    wait_done("rm_clean_done");
    wait_drain("rm_clean_drain");
    checks++; if (popped.size() != 4) begin errors++; $display("FAIL rm_clean_count: got %0d entries want 4", popped.size()); end
    for (int i = 0; i < 4 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== exp_entry(i)) begin errors++; $display("FAIL rm_clean_entry%0d: got %h want %h", i, popped[i], exp_entry(i)); end
    end
    checks++; if (best_sad !== 16'd120 || best_idx !== 8'd1 || done_cnt != 1) begin errors++; $display("FAIL rm_clean_best: %0d@%0d dones=%0d want 120@1 dones=1", best_sad, best_idx, done_cnt); end
  endtask

  task automatic test_single_block();
    int n;
    // First frame leaves one entry queued.
    out_ready1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++; if (me_req1 !== 1'b1) begin errors++; $display("FAIL sb_req1: me_req=%0b want 1", me_req1); end
    ack1 = 1'b1; sad1 = 16'd50; mvec1 = 10'h021;
    @(posedge clk); #1;
    ack1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL sb_frame1_done: done not seen"); end
    @(posedge clk); #1;
    // Second frame: capture and pop on the same edge with one entry stored.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    ack1 = 1'b1; sad1 = 16'd40; mvec1 = 10'h0A2; out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    checks++; if (out_valid1 !== 1'b1 || out_data1 !== {8'd0, 16'd40, 10'h0A2}) begin errors++; $display("FAIL sb_push_pop: valid=%0b data=%h want 1/%h", out_valid1, out_data1, {8'd0, 16'd40, 10'h0A2}); end
    checks++; if (me_req1 !== 1'b0) begin errors++; $display("FAIL sb_req_low: me_req=%0b want 0", me_req1); end
    ack1 = 1'b0;
    @(posedge clk); #1;
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL sb_done_timing: done=%0b want 1", done1); end
    @(posedge clk); #1;
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0 || best_sad1 !== 16'd40) begin errors++; $display("FAIL sb_end: done=%0b busy=%0b best=%0d want 0/0/40", done1, busy1, best_sad1); end
    checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL sb_one_left: out_valid=%0b want 1", out_valid1); end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL sb_count_one: out_valid=%0b want 0 after single pop", out_valid1); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_handshake();
    test_ignored_start();
    test_reset_mid();
    test_single_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
